// File: rtl/temporal_encoder_pkg.sv
// Shared definitions for the temporal encoder and the associative memory stage:
// mode encodings, encoder FSM states and default widths.
package temporal_encoder_pkg;

    localparam int unsigned HV_DIMENSION_DEFAULT = 8;
    localparam int unsigned LABEL_WIDTH_DEFAULT  = 8;
    localparam int unsigned NGRAM_SIZE_DEFAULT   = 3;
    localparam int unsigned MODE_WIDTH           = 2;

    typedef enum logic [MODE_WIDTH-1:0] {
        MODE_TRAIN   = 2'd0,
        MODE_PREDICT = 2'd1
    } modeT;

    typedef enum logic {
        STATE_IDLE          = 1'b0,
        STATE_OUTPUT_STABLE = 1'b1
    } stateT;

endpackage

// File: rtl/temporal_encoder_if.sv
// Sample stream into the encoder and n-gram stream out of it.
// master = surrounding pipeline, slave = encoder.
interface temporal_encoder_if
    import temporal_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEFAULT,
    parameter int unsigned LABEL_WIDTH  = LABEL_WIDTH_DEFAULT
);
    logic                    ValidIn_SI;
    logic                    ReadyOut_SO;
    logic [0:HV_DIMENSION-1] HypervectorIn_DI;
    logic [MODE_WIDTH-1:0]   ModeIn_SI;
    logic [LABEL_WIDTH-1:0]  LabelIn_DI;

    logic                    ValidOut_SO;
    logic                    ReadyIn_SI;
    logic [0:HV_DIMENSION-1] HypervectorOut_DO;
    logic [MODE_WIDTH-1:0]   ModeOut_SO;
    logic [LABEL_WIDTH-1:0]  LabelOut_DO;

    modport master (
        output ValidIn_SI, HypervectorIn_DI, ModeIn_SI, LabelIn_DI, ReadyIn_SI,
        input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO, ModeOut_SO, LabelOut_DO
    );

    modport slave (
        input  ValidIn_SI, HypervectorIn_DI, ModeIn_SI, LabelIn_DI, ReadyIn_SI,
        output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO, ModeOut_SO, LabelOut_DO
    );

endinterface

// File: rtl/temporal_encoder_hv_rotate.sv
// Combinational circular shift of a hypervector by AMOUNT positions toward
// higher index (bit i lands on bit i+AMOUNT, wrapping past the last bit).
module hv_rotate
    import temporal_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEFAULT,
    parameter int unsigned AMOUNT       = 1
) (
    input  logic [0:HV_DIMENSION-1] VectorIn_DI,
    output logic [0:HV_DIMENSION-1] VectorOut_DO
);

    for (genvar i = 0; i < HV_DIMENSION; i++) begin : gRot
        assign VectorOut_DO[(i + AMOUNT) % HV_DIMENSION] = VectorIn_DI[i];
    end

endmodule

// File: rtl/temporal_encoder.sv
// Sliding-window n-gram encoder: binds the last NGRAM_SIZE spatial hypervectors
// with per-age rotation and XOR, emitting one n-gram per accepted sample.
module temporal_encoder
    import temporal_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEFAULT,
    parameter int unsigned NGRAM_SIZE   = NGRAM_SIZE_DEFAULT,
    parameter int unsigned LABEL_WIDTH  = LABEL_WIDTH_DEFAULT
) (
    input logic              CLK_CI,
    input logic              Reset_RI,
    temporal_encoder_if.slave encBus
);

    localparam int unsigned FILL_WIDTH = $clog2(NGRAM_SIZE + 1);

    stateT                   stateQ;
    logic                    readyQ;
    logic                    validQ;
    logic [0:HV_DIMENSION-1] hvOutQ;
    logic [MODE_WIDTH-1:0]   modeOutQ;
    logic [LABEL_WIDTH-1:0]  labelOutQ;

    logic [0:HV_DIMENSION-1] historyQ    [NGRAM_SIZE];
    logic [0:HV_DIMENSION-1] historyNext [NGRAM_SIZE];
    logic [0:HV_DIMENSION-1] rotated     [NGRAM_SIZE];
    logic [0:HV_DIMENSION-1] ngram;
    logic [FILL_WIDTH-1:0]   fillCountQ;
    logic [FILL_WIDTH-1:0]   fillNext;
    logic [MODE_WIDTH-1:0]   lastModeQ;
    logic [LABEL_WIDTH-1:0]  lastLabelQ;
    logic                    accept;
    logic                    flush;

    assign accept = encBus.ValidIn_SI & readyQ;
    assign flush  = (encBus.ModeIn_SI != lastModeQ) || (encBus.LabelIn_DI != lastLabelQ);

    // History as it will look after this sample is shifted in; a mode/label
    // change restarts the window with the new sample as its only entry.
    always_comb begin
        historyNext[0] = encBus.HypervectorIn_DI;
        for (int k = 1; k < NGRAM_SIZE; k++) begin
            historyNext[k] = flush ? '0 : historyQ[k-1];
        end
        if (flush) begin
            fillNext = FILL_WIDTH'(1);
        end else if (fillCountQ == FILL_WIDTH'(NGRAM_SIZE)) begin
            fillNext = fillCountQ;
        end else begin
            fillNext = fillCountQ + FILL_WIDTH'(1);
        end
    end

    for (genvar k = 0; k < NGRAM_SIZE; k++) begin : gSlot
        hv_rotate #(
            .HV_DIMENSION(HV_DIMENSION),
            .AMOUNT      (k)
        ) uRotate (
            .VectorIn_DI (historyNext[k]),
            .VectorOut_DO(rotated[k])
        );
    end

    always_comb begin
        ngram = '0;
        for (int k = 0; k < NGRAM_SIZE; k++) begin
            ngram = ngram ^ rotated[k];
        end
    end

    // Handshake FSM; ready/valid come straight from flops so ReadyIn_SI never
    // reaches ReadyOut_SO within a cycle.
    always_ff @(posedge CLK_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            stateQ     <= STATE_IDLE;
            readyQ     <= 1'b1;
            validQ     <= 1'b0;
            hvOutQ     <= '0;
            modeOutQ   <= '0;
            labelOutQ  <= '0;
            fillCountQ <= '0;
            lastModeQ  <= '0;
            lastLabelQ <= '0;
            for (int k = 0; k < NGRAM_SIZE; k++) begin
                historyQ[k] <= '0;
            end
        end else begin
            case (stateQ)
                STATE_IDLE: begin
                    if (accept) begin
                        for (int k = 0; k < NGRAM_SIZE; k++) begin
                            historyQ[k] <= historyNext[k];
                        end
                        fillCountQ <= fillNext;
                        lastModeQ  <= encBus.ModeIn_SI;
                        lastLabelQ <= encBus.LabelIn_DI;
                        if (fillNext == FILL_WIDTH'(NGRAM_SIZE)) begin
                            hvOutQ    <= ngram;
                            modeOutQ  <= encBus.ModeIn_SI;
                            labelOutQ <= encBus.LabelIn_DI;
                            stateQ    <= STATE_OUTPUT_STABLE;
                            readyQ    <= 1'b0;
                            validQ    <= 1'b1;
                        end
                    end
                end
                STATE_OUTPUT_STABLE: begin
                    if (encBus.ReadyIn_SI) begin
                        stateQ <= STATE_IDLE;
                        readyQ <= 1'b1;
                        validQ <= 1'b0;
                    end
                end
                default: begin
                    stateQ <= STATE_IDLE;
                    readyQ <= 1'b1;
                    validQ <= 1'b0;
                end
            endcase
        end
    end

    assign encBus.ReadyOut_SO       = readyQ;
    assign encBus.ValidOut_SO       = validQ;
    assign encBus.HypervectorOut_DO = hvOutQ;
    assign encBus.ModeOut_SO        = modeOutQ;
    assign encBus.LabelOut_DO       = labelOutQ;

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench for temporal_encoder (HV_DIMENSION=8, NGRAM_SIZE=3):
// a vector table for the sliding window plus hand sequences for handshake corners.
module tb_temporal_encoder;
    import temporal_encoder_pkg::*;

    logic CLK_CI   = 1'b0;
    logic Reset_RI = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    temporal_encoder_if #(.HV_DIMENSION(8), .LABEL_WIDTH(8)) bus ();

    temporal_encoder #(
        .HV_DIMENSION(8),
        .NGRAM_SIZE  (3),
        .LABEL_WIDTH (8)
    ) dut (
        .CLK_CI  (CLK_CI),
        .Reset_RI(Reset_RI),
        .encBus  (bus.slave)
    );

    always #5 CLK_CI = ~CLK_CI;

    typedef struct {
        logic [0:7] hv;
        logic [1:0] mode;
        logic [7:0] label;
        logic       expValid;
        logic [0:7] expHv;
    } vecT;

    vecT vecs [15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One sample through the input handshake; checks the cycle after the edge.
    task automatic sendSample(input string name, input logic [0:7] hv, input logic [1:0] mode,
                              input logic [7:0] label, input logic expValid, input logic [0:7] expHv);
        @(negedge CLK_CI);
        bus.ValidIn_SI       = 1'b1;
        bus.HypervectorIn_DI = hv;
        bus.ModeIn_SI        = mode;
        bus.LabelIn_DI       = label;
        @(posedge CLK_CI);
        #1;
        bus.ValidIn_SI = 1'b0;
        check({name, ".valid"}, 32'(bus.ValidOut_SO), 32'(expValid));
        check({name, ".ready"}, 32'(bus.ReadyOut_SO), 32'(!expValid));
        if (expValid) begin
            check({name, ".hv"}, 32'(bus.HypervectorOut_DO), 32'(expHv));
            check({name, ".mode"}, 32'(bus.ModeOut_SO), 32'(mode));
            check({name, ".label"}, 32'(bus.LabelOut_DO), 32'(label));
            if (bus.ReadyIn_SI) begin
                @(posedge CLK_CI);
                #1;
                check({name, ".idleValid"}, 32'(bus.ValidOut_SO), 32'd0);
                check({name, ".idleReady"}, 32'(bus.ReadyOut_SO), 32'd1);
            end
        end
    endtask

    task automatic applyReset();
        @(negedge CLK_CI);
        bus.ValidIn_SI = 1'b0;
        Reset_RI       = 1'b1;
        @(negedge CLK_CI);
        Reset_RI = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'b10000000, MODE_PREDICT, 8'd0, 1'b0, 8'b00000000};
        vecs[1]  = '{8'b00000000, MODE_PREDICT, 8'd0, 1'b0, 8'b00000000};
        vecs[2]  = '{8'b00000000, MODE_PREDICT, 8'd0, 1'b1, 8'b00100000};
        vecs[3]  = '{8'b00000001, MODE_PREDICT, 8'd0, 1'b1, 8'b00000001};
        vecs[4]  = '{8'b11000000, MODE_PREDICT, 8'd0, 1'b1, 8'b01000000};
        vecs[5]  = '{8'b00010000, MODE_PREDICT, 8'd0, 1'b1, 8'b00110000};
        vecs[6]  = '{8'b10101010, MODE_TRAIN,   8'd7, 1'b0, 8'b00000000};
        vecs[7]  = '{8'b00000011, MODE_TRAIN,   8'd7, 1'b0, 8'b00000000};
        vecs[8]  = '{8'b11110000, MODE_TRAIN,   8'd7, 1'b1, 8'b11011011};
        vecs[9]  = '{8'b00000001, MODE_TRAIN,   8'd9, 1'b0, 8'b00000000};
        vecs[10] = '{8'b00000000, MODE_TRAIN,   8'd9, 1'b0, 8'b00000000};
        vecs[11] = '{8'b00000000, MODE_TRAIN,   8'd9, 1'b1, 8'b01000000};
        vecs[12] = '{8'b11111111, MODE_PREDICT, 8'd9, 1'b0, 8'b00000000};
        vecs[13] = '{8'b00000000, MODE_PREDICT, 8'd9, 1'b0, 8'b00000000};
        vecs[14] = '{8'b00000000, MODE_PREDICT, 8'd9, 1'b1, 8'b11111111};

        bus.ValidIn_SI       = 1'b0;
        bus.HypervectorIn_DI = '0;
        bus.ModeIn_SI        = '0;
        bus.LabelIn_DI       = '0;
        bus.ReadyIn_SI       = 1'b1;
        repeat (2) @(negedge CLK_CI);
        Reset_RI = 1'b0;
        #1;
        check("reset.valid", 32'(bus.ValidOut_SO), 32'd0);
        check("reset.ready", 32'(bus.ReadyOut_SO), 32'd1);
        check("reset.hv", 32'(bus.HypervectorOut_DO), 32'd0);
        check("reset.mode", 32'(bus.ModeOut_SO), 32'd0);
        check("reset.label", 32'(bus.LabelOut_DO), 32'd0);

        for (int i = 0; i < 15; i++) begin
            sendSample($sformatf("vec%0d", i), vecs[i].hv, vecs[i].mode, vecs[i].label,
                       vecs[i].expValid, vecs[i].expHv);
        end

        // Backpressure: held valid is ignored while the n-gram waits.
        applyReset();
        sendSample("bp.a", 8'b10000000, MODE_PREDICT, 8'd0, 1'b0, 8'b0);
        sendSample("bp.b", 8'b00000000, MODE_PREDICT, 8'd0, 1'b0, 8'b0);
        bus.ReadyIn_SI = 1'b0;
        sendSample("bp.c", 8'b00000000, MODE_PREDICT, 8'd0, 1'b1, 8'b00100000);
        @(negedge CLK_CI);
        bus.ValidIn_SI       = 1'b1;
        bus.HypervectorIn_DI = 8'b00000001;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK_CI);
            #1;
            check($sformatf("bp.hold%0d.valid", c), 32'(bus.ValidOut_SO), 32'd1);
            check($sformatf("bp.hold%0d.ready", c), 32'(bus.ReadyOut_SO), 32'd0);
            check($sformatf("bp.hold%0d.hv", c), 32'(bus.HypervectorOut_DO), 32'(8'b00100000));
        end
        @(negedge CLK_CI);
        bus.ReadyIn_SI = 1'b1;
        @(posedge CLK_CI);
        #1;
        check("bp.release.valid", 32'(bus.ValidOut_SO), 32'd0);
        check("bp.release.ready", 32'(bus.ReadyOut_SO), 32'd1);
        @(posedge CLK_CI);
        #1;
        bus.ValidIn_SI = 1'b0;
        check("bp.accept.valid", 32'(bus.ValidOut_SO), 32'd1);
        check("bp.accept.hv", 32'(bus.HypervectorOut_DO), 32'(8'b00000001));
        @(posedge CLK_CI);
        #1;
        check("bp.after.valid", 32'(bus.ValidOut_SO), 32'd0);

        // Label change: only the three label-5 samples form an n-gram.
        applyReset();
        sendSample("lbl.0", 8'b11111111, MODE_TRAIN, 8'd3, 1'b0, 8'b0);
        sendSample("lbl.1", 8'b11111111, MODE_TRAIN, 8'd3, 1'b0, 8'b0);
        sendSample("lbl.2", 8'b10000000, MODE_TRAIN, 8'd5, 1'b0, 8'b0);
        sendSample("lbl.3", 8'b00000000, MODE_TRAIN, 8'd5, 1'b0, 8'b0);
        sendSample("lbl.4", 8'b00000000, MODE_TRAIN, 8'd5, 1'b1, 8'b00100000);

        // Reset while an n-gram is pending, then refill from scratch.
        applyReset();
        bus.ReadyIn_SI = 1'b0;
        sendSample("rst.0", 8'b00000001, MODE_PREDICT, 8'd0, 1'b0, 8'b0);
        sendSample("rst.1", 8'b00000000, MODE_PREDICT, 8'd0, 1'b0, 8'b0);
        sendSample("rst.2", 8'b00000000, MODE_PREDICT, 8'd0, 1'b1, 8'b01000000);
        @(negedge CLK_CI);
        Reset_RI = 1'b1;
        #1;
        check("rst.mid.valid", 32'(bus.ValidOut_SO), 32'd0);
        check("rst.mid.hv", 32'(bus.HypervectorOut_DO), 32'd0);
        check("rst.mid.mode", 32'(bus.ModeOut_SO), 32'd0);
        @(negedge CLK_CI);
        Reset_RI       = 1'b0;
        bus.ReadyIn_SI = 1'b1;
        #1;
        check("rst.release.ready", 32'(bus.ReadyOut_SO), 32'd1);
        sendSample("rst.3", 8'b00000000, MODE_PREDICT, 8'd0, 1'b0, 8'b0);
        sendSample("rst.4", 8'b00000000, MODE_PREDICT, 8'd0, 1'b0, 8'b0);
        sendSample("rst.5", 8'b00000001, MODE_PREDICT, 8'd0, 1'b1, 8'b00000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/temporal_encoder.md
TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

Interface
REQ-001 SHALL have parameter HV_DIMENSION, default 8, hypervector width in bits (bit 0 = MSB, index [0:HV_DIMENSION-1]).
REQ-002 SHALL have parameter NGRAM_SIZE, default 3, n-gram length N (legal range 2..16).
REQ-003 SHALL have parameter LABEL_WIDTH, default 8, class label width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high. Ports: CLK_CI input 1, clock; Reset_RI input 1, asynchronous active-high reset.
REQ-005 SHALL have ports ValidIn_SI input 1 (upstream sample valid) and ReadyOut_SO output 1 (encoder can accept).
REQ-006 SHALL have ports HypervectorIn_DI input HV_DIMENSION (spatial hypervector), ModeIn_SI input 2 (mode_train/mode_predict) and LabelIn_DI input LABEL_WIDTH (training label).
REQ-007 SHALL have ports ValidOut_SO output 1 (n-gram valid) and ReadyIn_SI input 1 (associative memory ready).
REQ-008 SHALL have ports HypervectorOut_DO output HV_DIMENSION (n-gram hypervector), ModeOut_SO output 2 and LabelOut_DO output LABEL_WIDTH (mode/label aligned with n-gram).

Function
REQ-009 SHALL accept a sample only on a cycle with ValidIn_SI=1 and ReadyOut_SO=1.
REQ-010 SHALL keep a history of the last N accepted samples, x_t newest; on accept, shift history by one, x_t into slot 0, oldest discarded.
REQ-011 SHALL define rot(v) as circular shift by one toward higher index: bit i moves to i+1, bit HV_DIMENSION-1 moves to bit 0.
REQ-012 SHALL compute n-gram = XOR over k=0..N-1 of rot^k(x_{t-k}).
REQ-013 SHALL keep FillCount, counting accepted samples since last flush, saturating at N.
REQ-014 SHALL use FSM states idle and output_stable.
REQ-015 In idle: ReadyOut_SO=1, ValidOut_SO=0; on accept with post-accept FillCount=N -> register n-gram, mode, label into output registers, go to output_stable; otherwise stay idle.
REQ-016 In output_stable: ReadyOut_SO=0, ValidOut_SO=1, outputs held stable; ReadyIn_SI=1 -> idle next cycle; ReadyIn_SI=0 -> stay.
REQ-017 Latency: ValidOut_SO SHALL rise the cycle after the accepting edge; throughput is one n-gram per two cycles at most.
REQ-018 Once FillCount=N, every further accept SHALL produce one n-gram (sliding window, stride 1).
REQ-019 Mode/label change: if an accepted ModeIn_SI or LabelIn_DI differs from the previous accepted sample, history SHALL be flushed before the shift, so the new sample is the only entry and FillCount=1.
REQ-020 ModeOut_SO/LabelOut_DO SHALL carry the values of the newest sample in the n-gram.
REQ-021 ValidIn_SI while ReadyOut_SO=0 SHALL be ignored; history and FillCount are unchanged.
REQ-022 SHALL handle ValidOut_SO/ReadyIn_SI purely as a register-output handshake; no combinational path from ReadyIn_SI to ReadyOut_SO.

Reset
REQ-023 Reset_RI=1 SHALL asynchronously force FSM to idle, FillCount=0, history all zero, HypervectorOut_DO=0, ModeOut_SO=0, LabelOut_DO=0, ValidOut_SO=0, ReadyOut_SO=1 after release.
REQ-024 Reset mid-output (output_stable) SHALL drop ValidOut_SO immediately and discard the pending n-gram.

Structure
REQ-025 Shared package SHALL hold mode encodings (mode_train, mode_predict), FSM state constants and HV_DIMENSION/LABEL_WIDTH defaults, also used by associate_memory_cmb_arc.
REQ-026 SHALL have one sub-module hv_rotate (parameter HV_DIMENSION, AMOUNT; combinational circular shift) instantiated per history slot.

Verification (HV_DIMENSION=8, N=3)
REQ-027 Predict: x0=10000000, x1=00000000, x2=00000000 -> one ValidOut_SO after x2, HypervectorOut_DO=00100000; no output after x0/x1.
REQ-028 Continuing: x3=00000001 -> HypervectorOut_DO=00000001 (x0 drops out of window).
REQ-029 Wrap-around: after reset x0=00000001, x1=0, x2=0 -> HypervectorOut_DO=01000000.
REQ-030 Backpressure: ReadyIn_SI=0 for 5 cycles with ValidIn_SI=1 held -> output stable, ReadyOut_SO=0, history unchanged; ReadyIn_SI=1 -> idle next cycle, one accept.
REQ-031 Label change: train label 3 for 2 samples then label 5 for 3 samples -> exactly one n-gram, LabelOut_DO=5, built from label-5 samples only.
REQ-032 Reset asserted in output_stable -> ValidOut_SO=0 same cycle; then 3 fresh samples are needed before the next output.
